// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier (DTC) blocks.
//   CODE_W   : width of a classifier result code
//   state_t  : vote accumulator FSM states
//   majority : strict per-bit majority test, 2*cnt > n (ties give 0)
package dtc_pkg;

  localparam int unsigned CODE_W = 7;

  // Wide enough for any legal WINDOW (<= 255); callers zero-extend into it.
  localparam int unsigned MAJ_W = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  function automatic logic majority(input logic [MAJ_W-1:0] cnt,
                                    input logic [MAJ_W-1:0] n);
    logic [MAJ_W:0] twice;
    twice = {cnt, 1'b0};
    return twice > {1'b0, n};
  endfunction

endpackage

// File: rtl/dtc_vote_lane.sv
// One bit lane of the vote accumulator: counts how many accepted samples had
// this code bit set and reports the strict-majority bit for the window as it
// will stand after the current cycle's accept.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   accept       : a sample is accepted this cycle
//   sample_bit   : this lane's bit of the accepted code
//   clear        : result handed off; start a fresh window
//   n_next       : sample count including this cycle's accept
//   vote         : majority of (cnt_next, n_next)
module dtc_vote_lane #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             sample_bit,
  input  logic             clear,
  input  logic [CNT_W-1:0] n_next,
  output logic             vote
);
  import dtc_pkg::*;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + CNT_W'(accept & sample_bit);
  end

  assign vote = majority(MAJ_W'(cnt_next), MAJ_W'(n_next));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/dtc_vote_accumulator.sv
// Majority-vote smoother behind the decision-tree classifier. Accumulates
// per-bit set counts over WINDOW accepted codes (or fewer on flush) and emits
// one strict-majority code per window.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake, in_code sampled on accept
//   flush                : close a non-empty window early
//   out_valid/out_ready  : result handshake
//   out_code, out_n      : voted code and number of samples it covers
//   win_count            : results handed off (wraps at 16 bits)
module dtc_vote_accumulator #(
  parameter  int unsigned CODE_W = dtc_pkg::CODE_W,
  parameter  int unsigned WINDOW = 8,
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  out_n,
  output logic [15:0]       win_count
);
  import dtc_pkg::*;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  n_next;
  logic [CODE_W-1:0] votes;
  logic              accept;
  logic              close;
  logic              handoff;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EMIT);

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;
  assign n_next  = n + CNT_W'(accept);

  // n_next already includes a same-cycle accept, so a flush alongside the
  // sample that would otherwise open the window still closes it non-empty.
  assign close = (state == ACCUM) &&
                 ((accept && (n_next == CNT_W'(WINDOW))) ||
                  (flush && (n_next != '0)));

  for (genvar i = 0; i < CODE_W; i++) begin : g_lane
    dtc_vote_lane #(
      .CNT_W(CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .sample_bit(in_code[i]),
      .clear     (handoff),
      .n_next    (n_next),
      .vote      (votes[i])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (close)   state_next = EMIT;
      EMIT:    if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      n         <= '0;
      out_code  <= '0;
      out_n     <= '0;
      win_count <= '0;
    end else begin
      state <= state_next;
      if (handoff) begin
        n         <= '0;
        win_count <= win_count + 16'd1;
      end else if (accept) begin
        n <= n_next;
      end
      if (close) begin
        out_code <= votes;
        out_n    <= n_next;
      end
    end
  end

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
module tb_dtc_vote_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_code;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic [3:0]  out_n;
  logic [15:0] win_count;

  // Second instance at the WINDOW = 1 boundary.
  logic        in_valid1;
  logic        in_ready1;
  logic [6:0]  in_code1;
  logic        flush1;
  logic        out_valid1;
  logic        out_ready1;
  logic [6:0]  out_code1;
  logic [0:0]  out_n1;
  logic [15:0] win_count1;

  int vectors;
  int miscompares;

  dtc_vote_accumulator #(.WINDOW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code (out_code),
    .out_n    (out_n),
    .win_count(win_count)
  );

  dtc_vote_accumulator #(.WINDOW(1)) dut_w1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .in_code  (in_code1),
    .flush    (flush1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .out_code (out_code1),
    .out_n    (out_n1),
    .win_count(win_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic [6:0]  in_code;
    logic        flush;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [6:0]  exp_code;
    logic [3:0]  exp_n;
    logic [15:0] exp_win;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [6:0] c,
                     input logic f, input logic o, input logic eir,
                     input logic eov, input logic [6:0] ec,
                     input logic [3:0] en, input logic [15:0] ew);
    vec_t t;
    t.rst = r; t.in_valid = v; t.in_code = c; t.flush = f; t.out_ready = o;
    t.exp_in_ready = eir; t.exp_out_valid = eov; t.exp_code = ec;
    t.exp_n = en; t.exp_win = ew;
    vecs.push_back(t);
  endtask

  // k accepts of code c while outputs are expected to stay in ACCUM with the
  // given held output registers.
  task automatic add_accepts(input int k, input logic [6:0] c,
                             input logic [6:0] hc, input logic [3:0] hn,
                             input logic [15:0] hw);
    for (int i = 0; i < k; i++) add(0, 1, c, 0, 0, 1, 0, hc, hn, hw);
  endtask

  task automatic check(input string name, input logic ok, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1; in_valid = 0; in_code = '0; flush = 0; out_ready = 0;
    in_valid1 = 0; in_code1 = '0; flush1 = 0; out_ready1 = 0;

    // reset state
    add(1, 0, 7'h00, 0, 0, 1, 0, 7'h00, 4'd0, 16'd0);
    // full window of 1011001
    add_accepts(7, 7'b1011001, 7'h00, 4'd0, 16'd0);
    add(0, 1, 7'b1011001, 0, 0, 0, 1, 7'b1011001, 4'd8, 16'd0);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'b1011001, 4'd8, 16'd1);
    // tie 4 vs 4 -> 0
    add_accepts(4, 7'b0000001, 7'b1011001, 4'd8, 16'd1);
    add_accepts(3, 7'b0000000, 7'b1011001, 4'd8, 16'd1);
    add(0, 1, 7'b0000000, 0, 0, 0, 1, 7'b0000000, 4'd8, 16'd1);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'b0000000, 4'd8, 16'd2);
    // early flush after 3 samples
    add(0, 1, 7'b0100001, 0, 0, 1, 0, 7'b0000000, 4'd8, 16'd2);
    add(0, 1, 7'b0100000, 0, 0, 1, 0, 7'b0000000, 4'd8, 16'd2);
    add(0, 1, 7'b0100001, 0, 0, 1, 0, 7'b0000000, 4'd8, 16'd2);
    add(0, 0, 7'h00, 1, 0, 0, 1, 7'b0100001, 4'd3, 16'd2);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'b0100001, 4'd3, 16'd3);
    // flush on empty window is ignored
    add(0, 0, 7'h7f, 1, 0, 1, 0, 7'b0100001, 4'd3, 16'd3);
    add(0, 0, 7'h00, 0, 0, 1, 0, 7'b0100001, 4'd3, 16'd3);
    // accept + flush at n = 2 includes the flushing sample
    add(0, 1, 7'b0000001, 0, 0, 1, 0, 7'b0100001, 4'd3, 16'd3);
    add(0, 1, 7'b0000000, 0, 0, 1, 0, 7'b0100001, 4'd3, 16'd3);
    add(0, 1, 7'b0000001, 1, 0, 0, 1, 7'b0000001, 4'd3, 16'd3);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'b0000001, 4'd3, 16'd4);
    // backpressure: 5 stalled cycles with in_valid high
    add_accepts(7, 7'b1000000, 7'b0000001, 4'd3, 16'd4);
    add(0, 1, 7'b1000000, 0, 0, 0, 1, 7'b1000000, 4'd8, 16'd4);
    for (int i = 0; i < 5; i++) add(0, 1, 7'b0111111, 1, 0, 0, 1, 7'b1000000, 4'd8, 16'd4);
    add(0, 1, 7'b0111111, 0, 1, 1, 0, 7'b1000000, 4'd8, 16'd5);
    add_accepts(7, 7'b0111111, 7'b1000000, 4'd8, 16'd5);
    add(0, 1, 7'b0111111, 0, 0, 0, 1, 7'b0111111, 4'd8, 16'd5);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'b0111111, 4'd8, 16'd6);
    // reset mid-window at n = 5 clears counters and n
    add_accepts(5, 7'b1111111, 7'b0111111, 4'd8, 16'd6);
    add(1, 0, 7'h00, 0, 0, 1, 0, 7'h00, 4'd0, 16'd0);
    add_accepts(3, 7'b0000000, 7'h00, 4'd0, 16'd0);
    add(0, 0, 7'h00, 1, 0, 0, 1, 7'h00, 4'd3, 16'd0);
    add(0, 0, 7'h00, 0, 1, 1, 0, 7'h00, 4'd3, 16'd1);
    // reset during EMIT drops the pending result
    add_accepts(7, 7'b1111111, 7'h00, 4'd3, 16'd1);
    add(0, 1, 7'b1111111, 0, 0, 0, 1, 7'h7f, 4'd8, 16'd1);
    add(1, 0, 7'h00, 0, 0, 1, 0, 7'h00, 4'd0, 16'd0);
    add(0, 0, 7'h00, 1, 0, 1, 0, 7'h00, 4'd0, 16'd0);
    // flush during EMIT is ignored
    add_accepts(2, 7'b0000100, 7'h00, 4'd0, 16'd0);
    add(0, 0, 7'h00, 1, 0, 0, 1, 7'b0000100, 4'd2, 16'd0);
    add(0, 1, 7'h7f, 1, 0, 0, 1, 7'b0000100, 4'd2, 16'd0);
    add(0, 0, 7'h00, 1, 1, 1, 0, 7'b0000100, 4'd2, 16'd1);

    @(posedge clk);
    #1;
    foreach (vecs[k]) begin
      rst = vecs[k].rst; in_valid = vecs[k].in_valid; in_code = vecs[k].in_code;
      flush = vecs[k].flush; out_ready = vecs[k].out_ready;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k),
            (in_ready === vecs[k].exp_in_ready) && (out_valid === vecs[k].exp_out_valid) &&
            (out_code === vecs[k].exp_code) && (out_n === vecs[k].exp_n) &&
            (win_count === vecs[k].exp_win),
            $sformatf("got ir=%b ov=%b code=%b n=%0d win=%0d, want ir=%b ov=%b code=%b n=%0d win=%0d",
                      in_ready, out_valid, out_code, out_n, win_count,
                      vecs[k].exp_in_ready, vecs[k].exp_out_valid, vecs[k].exp_code,
                      vecs[k].exp_n, vecs[k].exp_win));
    end
    rst = 0; in_valid = 0; flush = 0; out_ready = 0;

    // WINDOW = 1: every accept closes a window of one sample.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] c;
      c = 7'(i * 37 + 5);
      in_valid1 = 1; in_code1 = c; out_ready1 = 0;
      @(posedge clk);
      #1;
      check($sformatf("w1_emit%0d", i),
            (out_valid1 === 1'b1) && (in_ready1 === 1'b0) &&
            (out_code1 === c) && (out_n1 === 1'b1),
            $sformatf("got ov=%b ir=%b code=%b n=%0d, want ov=1 ir=0 code=%b n=1",
                      out_valid1, in_ready1, out_code1, out_n1, c));
      in_valid1 = 0; out_ready1 = 1;
      @(posedge clk);
      #1;
      check($sformatf("w1_handoff%0d", i),
            (out_valid1 === 1'b0) && (in_ready1 === 1'b1) && (win_count1 === 16'(i + 1)),
            $sformatf("got ov=%b ir=%b win=%0d, want ov=0 ir=1 win=%0d",
                      out_valid1, in_ready1, win_count1, i + 1));
    end
    out_ready1 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
